// File: rtl/cfg_chain_loader.sv
// Configuration chain loader: takes words over valid/ready and shifts them LSB-first
// into a daisy-chained tile column, then pulses set once CHAIN_LEN bits are in.
module cfg_chain_loader #(
    parameter int unsigned CHAIN_LEN = 128,
    parameter int unsigned WORD_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              cen,
    output logic              shift_out,
    output logic              set_out,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    localparam int BIT_CW  = $clog2(CHAIN_LEN + 1);
    localparam int WORD_CW = $clog2(WORD_W + 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SHIFT, S_SET, S_DONE} state_t;

    state_t              state, state_n;
    logic [WORD_W-1:0]   sreg, sreg_n;
    logic [BIT_CW-1:0]   bits_left, bits_n;
    logic [WORD_CW-1:0]  word_left, word_n;
    logic                ready_n, cen_n, shift_n, set_n, done_n, aborted_n;

    // Outputs are decoded from the next state and registered, so the chain
    // sees cen/shift_out straight from flops.
    always_comb begin
        state_n   = state;
        sreg_n    = sreg;
        bits_n    = bits_left;
        word_n    = word_left;
        ready_n   = 1'b0;
        cen_n     = 1'b0;
        shift_n   = 1'b0;
        set_n     = 1'b0;
        done_n    = 1'b0;
        aborted_n = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_FETCH;
                    bits_n  = BIT_CW'(CHAIN_LEN);
                    ready_n = 1'b1;
                end
            end
            S_FETCH: begin
                if (abort) begin
                    state_n   = S_IDLE;
                    aborted_n = 1'b1;
                end else if (cfg_valid) begin
                    state_n = S_SHIFT;
                    sreg_n  = cfg_data;
                    if (32'(bits_left) < WORD_W)
                        word_n = WORD_CW'(bits_left);
                    else
                        word_n = WORD_CW'(WORD_W);
                    cen_n   = 1'b1;
                    shift_n = cfg_data[0];
                end else begin
                    ready_n = 1'b1;
                end
            end
            S_SHIFT: begin
                sreg_n = sreg >> 1;
                if (bits_left != '0)
                    bits_n = bits_left - BIT_CW'(1);
                if (word_left != '0)
                    word_n = word_left - WORD_CW'(1);
                if (abort) begin
                    state_n   = S_IDLE;
                    aborted_n = 1'b1;
                end else if (bits_left <= BIT_CW'(1)) begin
                    state_n = S_SET;
                    set_n   = 1'b1;
                end else if (word_left <= WORD_CW'(1)) begin
                    state_n = S_FETCH;
                    ready_n = 1'b1;
                end else begin
                    cen_n   = 1'b1;
                    shift_n = sreg_n[0];
                end
            end
            S_SET: begin
                state_n = S_DONE;
                done_n  = 1'b1;
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            sreg      <= '0;
            bits_left <= '0;
            word_left <= '0;
            cfg_ready <= 1'b0;
            cen       <= 1'b0;
            shift_out <= 1'b0;
            set_out   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            state     <= state_n;
            sreg      <= sreg_n;
            bits_left <= bits_n;
            word_left <= word_n;
            cfg_ready <= ready_n;
            cen       <= cen_n;
            shift_out <= shift_n;
            set_out   <= set_n;
            busy      <= (state_n != S_IDLE);
            done      <= done_n;
            aborted   <= aborted_n;
        end
    end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Directed bench for cfg_chain_loader: a 10-bit/4-bit-word chain and an 8-bit/8-bit-word chain.
module tb_cfg_chain_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, abort, valid, use8;
    logic [7:0] data;
    logic [7:0] words [3];

    logic r10, c10, so10, st10, b10, d10, a10;
    logic r8,  c8,  so8,  st8,  b8,  d8,  a8;
    logic m_ready, m_cen, m_shift, m_set, m_busy, m_done, m_aborted;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cfg_chain_loader #(.CHAIN_LEN(10), .WORD_W(4)) dut (
        .clk(clk), .rst(rst), .start(start & ~use8), .abort(abort & ~use8),
        .cfg_data(data[3:0]), .cfg_valid(valid & ~use8), .cfg_ready(r10),
        .cen(c10), .shift_out(so10), .set_out(st10), .busy(b10), .done(d10), .aborted(a10)
    );

    cfg_chain_loader #(.CHAIN_LEN(8), .WORD_W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start & use8), .abort(abort & use8),
        .cfg_data(data), .cfg_valid(valid & use8), .cfg_ready(r8),
        .cen(c8), .shift_out(so8), .set_out(st8), .busy(b8), .done(d8), .aborted(a8)
    );

    assign m_ready   = use8 ? r8  : r10;
    assign m_cen     = use8 ? c8  : c10;
    assign m_shift   = use8 ? so8 : so10;
    assign m_set     = use8 ? st8 : st10;
    assign m_busy    = use8 ? b8  : b10;
    assign m_done    = use8 ? d8  : d10;
    assign m_aborted = use8 ? a8  : a10;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives one load as a valid/ready source and records what the chain sees.
    task automatic run_load(input string tag, input bit sel8, input int nwords,
                            input int gap_word, input int gap_len, input int abort_cen,
                            input int start_cen, input logic [15:0] exp_bits,
                            input int exp_ncen, input int exp_hs, input bit exp_abort);
        int idx = 0, gapcnt = 0, cyc = 0, ncen = 0, nhs = 0, nset = 0, ndone = 0, nab = 0;
        int hs_cyc = 0, last_cen = 0, set_cyc = 0, done_cyc = 0, ab_cyc = 0, extra = 0;
        bit hs_prev = 0, finished = 0;
        logic [15:0] cap = '0;
        use8 = sel8;
        @(posedge clk); #1 start = 1'b1;
        for (int c = 0; c < 120 && !finished; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            abort = 1'b0;
            if (hs_prev) idx++;
            hs_prev = 0;
            if (idx == gap_word && gapcnt < gap_len) begin
                valid = 1'b0;
                if (m_ready) gapcnt++;
            end else begin
                valid = (idx < nwords);
                data  = (idx < 3) ? words[idx] : 8'h00;
            end
            @(negedge clk);
            cyc++;
            if (valid && m_ready) begin
                nhs++;
                hs_prev = 1;
                hs_cyc  = cyc;
            end
            if (m_cen) begin
                if (ncen < 16) cap[ncen] = m_shift;
                ncen++;
                last_cen = cyc;
                if (ncen == abort_cen) abort = 1'b1;
                if (ncen == start_cen) start = 1'b1;
            end
            if (m_set) begin
                nset++;
                set_cyc = cyc;
            end
            if (m_done) begin
                ndone++;
                done_cyc = cyc;
                finished = 1;
            end
            if (m_aborted) begin
                nab++;
                ab_cyc = cyc;
                finished = 1;
            end
        end
        valid = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        check({tag, "_finish"}, 32'(finished), 1);
        check({tag, "_ncen"}, ncen, exp_ncen);
        check({tag, "_bits"}, 32'(cap), 32'(exp_bits));
        check({tag, "_handshakes"}, nhs, exp_hs);
        if (gap_len > 0) check({tag, "_gaplen"}, gapcnt, gap_len);
        if (exp_abort) begin
            check({tag, "_aborted"}, nab, 1);
            check({tag, "_abort_lat"}, ab_cyc, last_cen + 1);
            check({tag, "_no_set"}, nset + ndone, 0);
        end else begin
            check({tag, "_nset"}, nset, 1);
            check({tag, "_set_lat"}, set_cyc, last_cen + 1);
            check({tag, "_done_lat"}, done_cyc, set_cyc + 1);
            check({tag, "_no_abort"}, nab, 0);
            if (sel8) check({tag, "_set_from_hs"}, set_cyc - hs_cyc, 9);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (m_busy || m_ready || m_cen || m_set) extra++;
        end
        check({tag, "_idle_after"}, extra, 0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        valid = 1'b0;
        use8  = 1'b0;
        data  = '0;
        words[0] = 8'h05;
        words[1] = 8'h0A;
        words[2] = 8'h03;
        repeat (2) @(negedge clk);
        check("reset_out10", {r10, c10, so10, st10, b10, d10, a10}, 0);
        check("reset_out8",  {r8, c8, so8, st8, b8, d8, a8}, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Words 5, A, 3 -> shifted bits concatenate to 0x3A5 (bit 0 first).
        run_load("basic", 0, 3, -1, 0, 0, 0, 16'h03A5, 10, 3, 0);
        run_load("gap",   0, 3,  1, 5, 0, 0, 16'h03A5, 10, 3, 0);
        run_load("abort", 0, 3, -1, 0, 6, 0, 16'h0025, 6, 2, 1);
        run_load("after_abort", 0, 3, -1, 0, 0, 0, 16'h03A5, 10, 3, 0);

        words[0] = 8'hC3;
        run_load("w8", 1, 1, -1, 0, 0, 0, 16'h00C3, 8, 1, 0);
        words[0] = 8'h05;

        use8 = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0; valid = 1'b1; data = 8'h05;
        @(posedge clk); #1 valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_pre_cen", 32'(c10), 1);
        #2 rst = 1'b1;
        #1 check("rst_async_out", {r10, c10, so10, st10, b10, d10, a10}, 0);
        @(posedge clk); #1 rst = 1'b0;
        run_load("post_rst", 0, 3, -1, 0, 0, 0, 16'h03A5, 10, 3, 0);

        valid = 1'b1;
        data  = 8'h05;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("idle_valid_ready", {r10, b10, c10}, 0);
        end
        valid = 1'b0;
        run_load("busy_start", 0, 3, -1, 0, 0, 3, 16'h03A5, 10, 3, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
